// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: unit codes, function codes,
// flag bit positions and FSM state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'd0,
    UNIT_LOGIC = 2'd1,
    UNIT_CMP   = 2'd2,
    UNIT_SHIFT = 2'd3
  } unit_t;

  localparam logic [3:0] FUN_ADD  = 4'h0;
  localparam logic [3:0] FUN_SUB  = 4'h1;
  localparam logic [3:0] FUN_MUL  = 4'h2;
  localparam logic [3:0] FUN_ADDC = 4'h3;
  localparam logic [3:0] FUN_AND  = 4'h4;
  localparam logic [3:0] FUN_OR   = 4'h5;
  localparam logic [3:0] FUN_XOR  = 4'h6;
  localparam logic [3:0] FUN_NAND = 4'h7;
  localparam logic [3:0] FUN_LT   = 4'h8;
  localparam logic [3:0] FUN_EQ   = 4'h9;
  localparam logic [3:0] FUN_GT   = 4'hA;
  localparam logic [3:0] FUN_NE   = 4'hB;
  localparam logic [3:0] FUN_SHL  = 4'hC;
  localparam logic [3:0] FUN_SHR  = 4'hD;
  localparam logic [3:0] FUN_ROL  = 4'hE;
  localparam logic [3:0] FUN_ROR  = 4'hF;

  // Bit positions inside the {ARITH,LOGIC,CMP,SHIFT} flag vector.
  localparam int FLAG_ARITH = 3;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 1;
  localparam int FLAG_SHIFT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] unit_flag(unit_t u);
    logic [3:0] f;
    f = 4'b0000;
    case (u)
      UNIT_ARITH: f[FLAG_ARITH] = 1'b1;
      UNIT_LOGIC: f[FLAG_LOGIC] = 1'b1;
      UNIT_CMP:   f[FLAG_CMP]   = 1'b1;
      default:    f[FLAG_SHIFT] = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command/response handshake bundle between the instruction front end (master)
// and the ALU command issuer (slave).
interface alu_cmd_issuer_if
  import alu_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int RES_WIDTH = A_WIDTH + B_WIDTH
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_fun;
  logic [A_WIDTH-1:0]   cmd_a;
  logic [B_WIDTH-1:0]   cmd_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RES_WIDTH-1:0] rsp_data;
  logic                 rsp_carry;
  unit_t                rsp_unit;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_unit, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_unit, rsp_err
  );

endinterface

// File: rtl/alu_result_mux.sv
// Selects the ALU unit output named by the unit code, zero-extends it, gates
// the carry to the arithmetic unit and flags a unit/flag mismatch.
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int RES_WIDTH = 32
) (
  input  unit_t                i_unit,
  input  logic [RES_WIDTH-1:0] i_arith_out,
  input  logic                 i_carry,
  input  logic [A_WIDTH-1:0]   i_logic_out,
  input  logic [2:0]           i_cmp_out,
  input  logic [A_WIDTH-1:0]   i_shift_out,
  input  logic [3:0]           i_flags,
  output logic [RES_WIDTH-1:0] o_data,
  output logic                 o_carry,
  output logic                 o_err
);

  always_comb begin
    o_data  = '0;
    o_carry = 1'b0;
    case (i_unit)
      UNIT_ARITH: begin
        o_data  = i_arith_out;
        o_carry = i_carry;
      end
      UNIT_LOGIC: o_data = RES_WIDTH'(i_logic_out);
      UNIT_CMP:   o_data = RES_WIDTH'(i_cmp_out);
      default:    o_data = RES_WIDTH'(i_shift_out);
    endcase
    // Exactly the selected unit's flag must be set; anything else is an error.
    o_err = (i_flags != unit_flag(i_unit));
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to ALU_TOP, waits out its registered latency,
// captures the selected unit result and returns it on the response port.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int RES_WIDTH = A_WIDTH + B_WIDTH,
  parameter int ALU_LAT   = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  alu_cmd_issuer_if.slave      s_if,
  output logic [A_WIDTH-1:0]   o_alu_a,
  output logic [B_WIDTH-1:0]   o_alu_b,
  output logic [3:0]           o_alu_fun,
  input  logic [RES_WIDTH-1:0] i_alu_arith_out,
  input  logic                 i_alu_carry,
  input  logic [A_WIDTH-1:0]   i_alu_logic_out,
  input  logic [2:0]           i_alu_cmp_out,
  input  logic [A_WIDTH-1:0]   i_alu_shift_out,
  input  logic [3:0]           i_alu_flags,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_ops_done
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);

  state_t               r_state;
  logic [LAT_W-1:0]     r_cnt;
  logic [A_WIDTH-1:0]   r_alu_a;
  logic [B_WIDTH-1:0]   r_alu_b;
  logic [3:0]           r_alu_fun;
  logic                 r_rsp_valid;
  logic [RES_WIDTH-1:0] r_rsp_data;
  logic                 r_rsp_carry;
  unit_t                r_rsp_unit;
  logic                 r_rsp_err;
  logic [CNT_WIDTH-1:0] r_ops_done;

  unit_t                w_unit;
  logic [RES_WIDTH-1:0] w_data;
  logic                 w_carry;
  logic                 w_err;

  assign w_unit = unit_t'(r_alu_fun[3:2]);

  alu_result_mux #(
    .A_WIDTH   (A_WIDTH),
    .RES_WIDTH (RES_WIDTH)
  ) u_mux (
    .i_unit      (w_unit),
    .i_arith_out (i_alu_arith_out),
    .i_carry     (i_alu_carry),
    .i_logic_out (i_alu_logic_out),
    .i_cmp_out   (i_alu_cmp_out),
    .i_shift_out (i_alu_shift_out),
    .i_flags     (i_alu_flags),
    .o_data      (w_data),
    .o_carry     (w_carry),
    .o_err       (w_err)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_unit  <= UNIT_ARITH;
      r_rsp_err   <= 1'b0;
      r_ops_done  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_if.cmd_valid) begin
            r_alu_a   <= s_if.cmd_a;
            r_alu_b   <= s_if.cmd_b;
            r_alu_fun <= s_if.cmd_fun;
            r_cnt     <= LAT_W'(ALU_LAT);
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Counter reaches zero on the edge the ALU output becomes valid.
          if (r_cnt == '0) begin
            r_rsp_data  <= w_data;
            r_rsp_carry <= w_carry;
            r_rsp_unit  <= w_unit;
            r_rsp_err   <= w_err;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (s_if.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + CNT_WIDTH'(1);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_if.cmd_ready = (r_state == ST_IDLE);
  assign s_if.rsp_valid = r_rsp_valid;
  assign s_if.rsp_data  = r_rsp_data;
  assign s_if.rsp_carry = r_rsp_carry;
  assign s_if.rsp_unit  = r_rsp_unit;
  assign s_if.rsp_err   = r_rsp_err;

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_fun  = r_alu_fun;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_ops_done = r_ops_done;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer driving a behavioural one-cycle ALU model.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int AW = 16;
  localparam int BW = 16;
  localparam int RW = 32;
  localparam int CW = 2;

  typedef struct packed {
    logic [RW-1:0] data;
    logic          carry;
    logic [1:0]    unit;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.A_WIDTH(AW), .B_WIDTH(BW), .RES_WIDTH(RW)) u_if ();

  logic [AW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [3:0]    alu_fun;
  logic [RW-1:0] m_arith;
  logic          m_carry;
  logic [AW-1:0] m_logic;
  logic [2:0]    m_cmp;
  logic [AW-1:0] m_shift;
  logic [3:0]    m_flags;
  logic [3:0]    alu_flags;
  logic          force_en = 1'b0;
  logic [3:0]    force_val = 4'b0000;
  logic          busy;
  logic [CW-1:0] ops_done;

  assign alu_flags = force_en ? force_val : m_flags;

  alu_cmd_issuer #(
    .A_WIDTH(AW), .B_WIDTH(BW), .RES_WIDTH(RW), .ALU_LAT(1), .CNT_WIDTH(CW)
  ) u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .s_if            (u_if.slave),
    .o_alu_a         (alu_a),
    .o_alu_b         (alu_b),
    .o_alu_fun       (alu_fun),
    .i_alu_arith_out (m_arith),
    .i_alu_carry     (m_carry),
    .i_alu_logic_out (m_logic),
    .i_alu_cmp_out   (m_cmp),
    .i_alu_shift_out (m_shift),
    .i_alu_flags     (alu_flags),
    .o_busy          (busy),
    .o_ops_done      (ops_done)
  );

  // ALU model: every unit computes every cycle; carry is junk outside arith.
  always @(posedge clk) begin
    logic [AW:0] s;
    case (alu_fun[1:0])
      2'd0: s = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1: s = {1'b0, alu_a} - {1'b0, alu_b};
      2'd3: s = {1'b0, alu_a} + {1'b0, alu_b} + 17'd1;
      default: s = '0;
    endcase
    m_arith <= (alu_fun[1:0] == 2'd2) ? RW'(alu_a) * RW'(alu_b) : RW'(s[AW-1:0]);
    m_carry <= (alu_fun[3:2] == 2'd0) ? s[AW] : 1'b1;
    case (alu_fun[1:0])
      2'd0: m_logic <= alu_a & alu_b;
      2'd1: m_logic <= alu_a | alu_b;
      2'd2: m_logic <= alu_a ^ alu_b;
      default: m_logic <= ~(alu_a & alu_b);
    endcase
    m_cmp   <= {alu_a < alu_b, alu_a == alu_b, alu_a > alu_b};
    m_shift <= alu_fun[0] ? (alu_a >> alu_b[3:0]) : (alu_a << alu_b[3:0]);
    m_flags <= 4'b1000 >> alu_fun[3:2];
  end

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];

  initial begin
    u_if.cmd_valid = 1'b0;
    u_if.cmd_fun   = 4'h0;
    u_if.cmd_a     = '0;
    u_if.cmd_b     = '0;
    u_if.rsp_ready = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic issue(input logic [3:0] fun, input logic [AW-1:0] a, input logic [BW-1:0] b,
                       output bit ok);
    bit pre;
    ok = 1'b0;
    u_if.cmd_fun   = fun;
    u_if.cmd_a     = a;
    u_if.cmd_b     = b;
    u_if.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      pre = u_if.cmd_ready;
      @(posedge clk);
      #1;
      if (pre) begin
        ok = 1'b1;
        break;
      end
    end
    u_if.cmd_valid = 1'b0;
    $display("cmd fun=%h a=%h b=%h accepted=%0d", fun, a, b, ok);
  endtask

  task automatic collect(output rsp_t o, output int waits, output bit ok);
    ok = 1'b0;
    waits = 0;
    o = '0;
    for (int i = 0; i < 50; i++) begin
      if (u_if.rsp_valid) begin
        o = {u_if.rsp_data, u_if.rsp_carry, u_if.rsp_unit, u_if.rsp_err};
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    $display("rsp data=%h carry=%0d unit=%0d err=%0d waits=%0d ok=%0d",
             o.data, o.carry, o.unit, o.err, waits, ok);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({u_if.cmd_ready, u_if.rsp_valid, busy} !== 3'b100)
      begin errors++; $display("FAIL reset_ctrl got %b want 100", {u_if.cmd_ready, u_if.rsp_valid, busy}); end
    checks++;
    if ({alu_a, alu_b, alu_fun} !== 36'd0)
      begin errors++; $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_fun}); end
    checks++;
    if ({ops_done, u_if.rsp_data, u_if.rsp_err, u_if.rsp_carry} !== '0)
      begin errors++; $display("FAIL reset_rsp got %h want 0", {ops_done, u_if.rsp_data}); end
    rst = 1'b1;
    $display("reset done");
  endtask

  task automatic test_add();
    bit ok; int waits; rsp_t got, e;
    u_if.rsp_ready = 1'b1;
    issue(FUN_ADD, 16'd24, 16'd4, ok);
    sb.push_back('{data: 32'h0000_001C, carry: 1'b0, unit: 2'd0, err: 1'b0});
    checks++;
    if (!ok) begin errors++; $display("FAIL add_accept got 0 want 1"); end
    checks++;
    if ({alu_a, alu_b, alu_fun, busy, u_if.cmd_ready} !== {16'd24, 16'd4, 4'h0, 1'b1, 1'b0})
      begin errors++; $display("FAIL add_drive got %h want %h", {alu_a, alu_b, alu_fun, busy, u_if.cmd_ready}, {16'd24, 16'd4, 4'h0, 1'b1, 1'b0}); end
    collect(got, waits, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || waits !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", waits); end
    checks++;
    if (got !== e) begin errors++; $display("FAIL add_rsp got %h want %h", got, e); end
    // Carry-out of the adder must come through on the arith unit.
    issue(FUN_ADD, 16'hFFFF, 16'h0001, ok);
    sb.push_back('{data: 32'h0, carry: 1'b1, unit: 2'd0, err: 1'b0});
    collect(got, waits, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL add_carry got %h want %h", got, e); end
  endtask

  task automatic test_mul_or();
    bit ok, pre_rv, pre_cr, got1; int hs_c, acc_c, waits; rsp_t got, e;
    u_if.rsp_ready = 1'b1;
    issue(FUN_MUL, 16'd24, 16'd4, ok);
    sb.push_back('{data: 32'h0000_0060, carry: 1'b0, unit: 2'd0, err: 1'b0});
    u_if.cmd_fun = FUN_OR; u_if.cmd_a = 16'd24; u_if.cmd_b = 16'd4; u_if.cmd_valid = 1'b1;
    got1 = 1'b0; hs_c = -1; acc_c = -1;
    for (int c = 0; c < 30; c++) begin
      pre_rv = u_if.rsp_valid;
      pre_cr = u_if.cmd_ready;
      if (pre_rv && !got1) got = {u_if.rsp_data, u_if.rsp_carry, u_if.rsp_unit, u_if.rsp_err};
      @(posedge clk);
      #1;
      if (pre_rv && !got1) begin got1 = 1'b1; hs_c = c; end
      if (pre_cr) begin acc_c = c; break; end
    end
    u_if.cmd_valid = 1'b0;
    e = sb.pop_front();
    $display("mul rsp data=%h handshake=%0d or_accept=%0d", got.data, hs_c, acc_c);
    checks++;
    if (!got1 || got !== e) begin errors++; $display("FAIL mul_rsp got %h want %h", got, e); end
    checks++;
    if (!got1 || acc_c !== hs_c + 1)
      begin errors++; $display("FAIL or_accept_order got %0d want %0d", acc_c, hs_c + 1); end
    sb.push_back('{data: 32'h0000_001C, carry: 1'b0, unit: 2'd1, err: 1'b0});
    collect(got, waits, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL or_rsp got %h want %h", got, e); end
  endtask

  task automatic test_backpressure();
    bit ok; rsp_t snap, e; logic [CW-1:0] snap_ops, want_ops;
    u_if.rsp_ready = 1'b0;
    issue(FUN_SUB, 16'd100, 16'd7, ok);
    sb.push_back('{data: 32'h0000_005D, carry: 1'b0, unit: 2'd0, err: 1'b0});
    for (int i = 0; i < 20 && !u_if.rsp_valid; i++) begin @(posedge clk); #1; end
    snap = {u_if.rsp_data, u_if.rsp_carry, u_if.rsp_unit, u_if.rsp_err};
    snap_ops = ops_done;
    e = sb.pop_front();
    checks++;
    if (!u_if.rsp_valid || snap !== e) begin errors++; $display("FAIL bp_rsp got %h want %h", snap, e); end
    // A competing command during backpressure must not disturb the ALU inputs.
    u_if.cmd_fun = FUN_ROR; u_if.cmd_a = 16'h1234; u_if.cmd_b = 16'h0002; u_if.cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({u_if.rsp_valid, u_if.rsp_data, u_if.rsp_carry, u_if.rsp_unit, u_if.rsp_err} !== {1'b1, e})
        begin errors++; $display("FAIL bp_hold_rsp cyc=%0d got %h want %h", c, {u_if.rsp_data, u_if.rsp_unit}, {e.data, e.unit}); end
      checks++;
      if ({u_if.cmd_ready, alu_a, alu_b, alu_fun, ops_done} !== {1'b0, 16'd100, 16'd7, 4'h1, snap_ops})
        begin errors++; $display("FAIL bp_hold_alu cyc=%0d got %h want %h", c, {u_if.cmd_ready, alu_a, alu_b, alu_fun, ops_done}, {1'b0, 16'd100, 16'd7, 4'h1, snap_ops}); end
    end
    u_if.cmd_valid = 1'b0;
    u_if.rsp_ready = 1'b1;
    want_ops = snap_ops + 2'd1;
    @(posedge clk);
    #1;
    checks++;
    if ({u_if.rsp_valid, ops_done} !== {1'b0, want_ops})
      begin errors++; $display("FAIL bp_release got %h want %h", {u_if.rsp_valid, ops_done}, {1'b0, want_ops}); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ops_done !== want_ops) begin errors++; $display("FAIL bp_once got %0d want %0d", ops_done, want_ops); end
    $display("backpressure released ops_done=%0d", ops_done);
  endtask

  task automatic test_flag_err();
    bit ok; int waits; rsp_t got, e;
    u_if.rsp_ready = 1'b1;
    force_en = 1'b1;
    force_val = 4'b0100;
    issue(FUN_ADD, 16'd24, 16'd4, ok);
    sb.push_back('{data: 32'h0000_001C, carry: 1'b0, unit: 2'd0, err: 1'b1});
    collect(got, waits, ok);
    force_en = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL flag_err got %h want %h", got, e); end
  endtask

  task automatic test_reset_wait();
    bit ok, seen;
    do_reset();
    u_if.rsp_ready = 1'b1;
    issue(FUN_ADD, 16'd24, 16'd4, ok);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if ({busy, u_if.cmd_ready, u_if.rsp_valid, ops_done, alu_a} !== {1'b0, 1'b1, 1'b0, 2'd0, 16'd0})
      begin errors++; $display("FAIL rst_wait_state got %h want %h", {busy, u_if.cmd_ready, u_if.rsp_valid, ops_done, alu_a}, {1'b0, 1'b1, 1'b0, 2'd0, 16'd0}); end
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (u_if.rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || ops_done !== 2'd0)
      begin errors++; $display("FAIL rst_wait_no_rsp got %0d/%0d want 0/0", seen, ops_done); end
    $display("reset in wait done");
  endtask

  task automatic test_wrap();
    bit ok; int waits; rsp_t got, e;
    logic [3:0]    funs [5] = '{FUN_LT, FUN_SHL, FUN_SUB, FUN_XOR, FUN_ADD};
    logic [AW-1:0] as   [5] = '{16'd5, 16'h0003, 16'd100, 16'hF0F0, 16'hFFFF};
    logic [BW-1:0] bs   [5] = '{16'd9, 16'd4, 16'd7, 16'hFF00, 16'h0001};
    rsp_t          exps [5] = '{'{32'h4, 1'b0, 2'd2, 1'b0}, '{32'h30, 1'b0, 2'd3, 1'b0},
                                '{32'h5D, 1'b0, 2'd0, 1'b0}, '{32'h0FF0, 1'b0, 2'd1, 1'b0},
                                '{32'h0, 1'b1, 2'd0, 1'b0}};
    logic [CW-1:0] seq  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    u_if.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      issue(funs[k], as[k], bs[k], ok);
      sb.push_back(exps[k]);
      collect(got, waits, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin errors++; $display("FAIL wrap_rsp%0d got %h want %h", k, got, e); end
      checks++;
      if (ops_done !== seq[k]) begin errors++; $display("FAIL wrap_ops%0d got %0d want %0d", k, ops_done, seq[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_or();
    test_backpressure();
    test_flag_err();
    test_reset_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
